// File: rtl/core_pkg.sv
// Shared types and constants for the register file / scoreboard slice.
package core_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam int unsigned XLEN                 = 32;
    localparam int unsigned NUM_REGS             = 32;
    localparam int unsigned CNT_W_DEFAULT        = 2;
    localparam int unsigned MAX_INFLIGHT_DEFAULT = 3;

    localparam reg_addr_t X0 = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register. A simultaneous inc
// and dec cancel out; clear takes priority over both. o_error pulses on an
// increment at MAX_INFLIGHT or a decrement at zero, and the count saturates.
module sb_counter #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_error
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Next count: saturating step, then flush clear overrides.
    always_comb begin
        w_count_next = r_count;
        o_error      = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count == MaxCnt) o_error = 1'b1;
            else                   w_count_next = r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) o_error = 1'b1;
            else               w_count_next = r_count - 1'b1;
        end
        if (i_clear) w_count_next = '0;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else       r_count <= w_count_next;
    end

    assign o_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with write-through reads and a per-register
// pending-write scoreboard that generates the decode stall.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  reg_addr_t       ID_rs1_addr,
    input  reg_addr_t       ID_rs2_addr,
    input  logic            ID_rs1_used,
    input  logic            ID_rs2_used,
    input  reg_addr_t       ID_rd_addr,
    input  logic            ID_rd_writes,
    input  logic            ID_issue_valid,
    output logic [XLEN-1:0] ID_rs1_data,
    output logic [XLEN-1:0] ID_rs2_data,
    output logic            ID_stall,
    input  logic            WB_regfile_write_valid,
    input  logic [XLEN-1:0] WB_regfile_write_data,
    input  reg_addr_t       WB_rd_addr,
    input  logic            flush,
    output logic            sb_error
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [XLEN-1:0]  r_regs [NUM_REGS];
    logic             r_sb_error;
    logic [CNT_W-1:0] w_pend [NUM_REGS];
    logic [NUM_REGS-1:0] w_cnt_err;
    logic             w_retire;
    logic             w_issue;
    logic             w_rs1_hazard;
    logic             w_rs2_hazard;
    logic             w_rd_full;

    assign w_retire = WB_regfile_write_valid && (WB_rd_addr != X0);
    assign w_issue  = ID_issue_valid && ID_rd_writes && (ID_rd_addr != X0) && !ID_stall && !flush;

    // x0 has no counter; it is never pending.
    assign w_pend[0]    = '0;
    assign w_cnt_err[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .MAX_INFLIGHT(MAX_INFLIGHT),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .i_inc  (w_issue && (ID_rd_addr == reg_addr_t'(g))),
            .i_dec  (w_retire && (WB_rd_addr == reg_addr_t'(g))),
            .i_clear(flush),
            .o_count(w_pend[g]),
            .o_error(w_cnt_err[g])
        );
    end

    // Hazard detection; a retire in flight this cycle resolves a last pending write.
    always_comb begin
        w_rs1_hazard = ID_rs1_used && (ID_rs1_addr != X0) && (w_pend[ID_rs1_addr] != '0)
                       && !((w_pend[ID_rs1_addr] == CntOne) && w_retire
                            && (WB_rd_addr == ID_rs1_addr));
        w_rs2_hazard = ID_rs2_used && (ID_rs2_addr != X0) && (w_pend[ID_rs2_addr] != '0)
                       && !((w_pend[ID_rs2_addr] == CntOne) && w_retire
                            && (WB_rd_addr == ID_rs2_addr));
        w_rd_full    = ID_rd_writes && (ID_rd_addr != X0) && (w_pend[ID_rd_addr] == MaxCnt)
                       && !(w_retire && (WB_rd_addr == ID_rd_addr));
        ID_stall     = ID_issue_valid && (w_rs1_hazard || w_rs2_hazard || w_rd_full);
    end

    // Operand reads with writeback bypass; x0 is hardwired to zero.
    always_comb begin
        ID_rs1_data = r_regs[ID_rs1_addr];
        ID_rs2_data = r_regs[ID_rs2_addr];
        if (w_retire && (WB_rd_addr == ID_rs1_addr)) ID_rs1_data = WB_regfile_write_data;
        if (w_retire && (WB_rd_addr == ID_rs2_addr)) ID_rs2_data = WB_regfile_write_data;
        if (ID_rs1_addr == X0) ID_rs1_data = '0;
        if (ID_rs2_addr == X0) ID_rs2_data = '0;
    end

    // Register array write; still performed during a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_retire) begin
            r_regs[WB_rd_addr] <= WB_regfile_write_data;
        end
    end

    // Sticky error flag collecting any counter under/overflow.
    always_ff @(posedge clk) begin
        if (reset) r_sb_error <= 1'b0;
        else       r_sb_error <= r_sb_error || (|w_cnt_err);
    end

    assign sb_error = r_sb_error;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver issues one input vector per cycle and pushes
// the reference model's expected outputs; the monitor pops and compares.
module tb_regfile_scoreboard;
    import core_pkg::*;

    localparam int MAXI = 3;

    logic            clk = 1'b0;
    logic            reset;
    reg_addr_t       ID_rs1_addr, ID_rs2_addr, ID_rd_addr, WB_rd_addr;
    logic            ID_rs1_used, ID_rs2_used, ID_rd_writes, ID_issue_valid;
    logic [31:0]     ID_rs1_data, ID_rs2_data, WB_regfile_write_data;
    logic            ID_stall, WB_regfile_write_valid, flush, sb_error;

    always #5 clk = ~clk;

    regfile_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ID_rs1_addr           (ID_rs1_addr),
        .ID_rs2_addr           (ID_rs2_addr),
        .ID_rs1_used           (ID_rs1_used),
        .ID_rs2_used           (ID_rs2_used),
        .ID_rd_addr            (ID_rd_addr),
        .ID_rd_writes          (ID_rd_writes),
        .ID_issue_valid        (ID_issue_valid),
        .ID_rs1_data           (ID_rs1_data),
        .ID_rs2_data           (ID_rs2_data),
        .ID_stall              (ID_stall),
        .WB_regfile_write_valid(WB_regfile_write_valid),
        .WB_regfile_write_data (WB_regfile_write_data),
        .WB_rd_addr            (WB_rd_addr),
        .flush                 (flush),
        .sb_error              (sb_error)
    );

    typedef struct packed {
        logic        stall;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: pending write counts and architectural register values.
    int          m_pend [32];
    logic [31:0] m_reg  [32];
    logic        m_err;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (WB_regfile_write_valid && WB_rd_addr == a) return WB_regfile_write_data;
        return m_reg[a];
    endfunction

    function automatic logic m_hazard(input logic used, input logic [4:0] a);
        if (!used || a == 0 || m_pend[a] == 0) return 1'b0;
        if (m_pend[a] == 1 && WB_regfile_write_valid && WB_rd_addr == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_stall();
        logic full;
        full = ID_rd_writes && ID_rd_addr != 0 && m_pend[ID_rd_addr] == MAXI
               && !(WB_regfile_write_valid && WB_rd_addr == ID_rd_addr);
        return ID_issue_valid && (m_hazard(ID_rs1_used, ID_rs1_addr)
                                  || m_hazard(ID_rs2_used, ID_rs2_addr) || full);
    endfunction

    // Apply the currently driven inputs as one clock edge.
    task automatic m_clock();
        logic issue, retire;
        int   delta;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_pend[r] = 0;
                m_reg[r]  = 32'd0;
            end
            m_err = 1'b0;
            return;
        end
        retire = WB_regfile_write_valid && WB_rd_addr != 0;
        issue  = ID_issue_valid && ID_rd_writes && ID_rd_addr != 0 && !m_stall() && !flush;
        for (int r = 1; r < 32; r++) begin
            delta = ((issue && ID_rd_addr == r) ? 1 : 0) - ((retire && WB_rd_addr == r) ? 1 : 0);
            if (delta < 0 && m_pend[r] == 0) m_err = 1'b1;
            if (delta > 0 && m_pend[r] == MAXI) m_err = 1'b1;
            if (flush) m_pend[r] = 0;
            else if (delta < 0 && m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
            else if (delta > 0 && m_pend[r] < MAXI) m_pend[r] = m_pend[r] + 1;
        end
        if (retire) m_reg[WB_rd_addr] = WB_regfile_write_data;
    endtask

    task automatic drv(input logic rst, input logic fl, input logic iv, input logic rdw,
                       input logic [4:0] rd, input logic u1, input logic [4:0] a1,
                       input logic u2, input logic [4:0] a2, input logic wbv,
                       input logic [4:0] wba, input logic [31:0] wbd);
        exp_t e;
        @(posedge clk);
        #1;
        m_clock();
        reset                  = rst;
        flush                  = fl;
        ID_issue_valid         = iv;
        ID_rd_writes           = rdw;
        ID_rd_addr             = rd;
        ID_rs1_used            = u1;
        ID_rs1_addr            = a1;
        ID_rs2_used            = u2;
        ID_rs2_addr            = a2;
        WB_regfile_write_valid = wbv;
        WB_rd_addr             = wba;
        WB_regfile_write_data  = wbd;
        e.stall = m_stall();
        e.d1    = m_read(a1);
        e.d2    = m_read(a2);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", {31'd0, ID_stall}, {31'd0, e.stall});
            chk("rs1_data", ID_rs1_data, e.d1);
            chk("rs2_data", ID_rs2_data, e.d2);
            chk("sb_error", {31'd0, sb_error}, {31'd0, e.err});
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 0;
            m_reg[r]  = 32'd0;
        end
        m_err = 1'b0;
        reset = 1'b1; flush = 1'b0; ID_issue_valid = 1'b0; ID_rd_writes = 1'b0;
        ID_rd_addr = '0; ID_rs1_used = 1'b0; ID_rs1_addr = '0; ID_rs2_used = 1'b0;
        ID_rs2_addr = '0; WB_regfile_write_valid = 1'b0; WB_rd_addr = '0;
        WB_regfile_write_data = '0;

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        idle();

        // RAW hazard on x5 resolved by a same-cycle writeback.
        drv(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 0, 0, 1, 5, 0, 0, 1, 5, 32'hDEADBEEF);
        drv(0, 0, 1, 0, 0, 1, 5, 1, 5, 0, 0, 32'd0);

        // Fill x7 to the in-flight limit; retire lets a fourth issue in.
        repeat (3) drv(0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 32'h00000077);
        drv(0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 0, 0, 1, 7, 0, 0, 1, 7, 32'h00000078);
        repeat (2) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h00000079);
        drv(0, 0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 32'd0);

        // Writes to x0 are ignored.
        drv(0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 32'h12345678);
        drv(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'd0);

        // Retire with nothing pending: sticky error until reset.
        drv(0, 0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 32'h99999999);
        repeat (10) idle();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        idle();

        // Flush clears pending state but the writeback still lands.
        drv(0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 1, 1, 1, 6, 1, 3, 1, 4, 1, 3, 32'hA5A5A5A5);
        drv(0, 0, 1, 0, 0, 1, 3, 1, 4, 0, 0, 32'd0);

        // Reset discards a pending x2 and its value.
        drv(0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'hFFFFFFFF);
        drv(0, 0, 1, 1, 2, 1, 2, 0, 0, 0, 0, 32'd0);
        drv(1, 0, 1, 1, 2, 1, 2, 0, 0, 0, 0, 32'd0);
        drv(0, 0, 1, 1, 2, 1, 2, 1, 2, 0, 0, 32'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            logic rst, fl, iv, rdw, u1, u2, wbv;
            logic [4:0] rd, a1, a2, wba;
            rst = ($urandom_range(99) < 2);
            fl  = ($urandom_range(99) < 3);
            iv  = ($urandom_range(9) < 8);
            rdw = ($urandom_range(9) < 7);
            rd  = 5'($urandom_range(7));
            u1  = $urandom_range(1) == 1;
            u2  = $urandom_range(1) == 1;
            a1  = 5'($urandom_range(7));
            a2  = 5'($urandom_range(7));
            wba = 5'($urandom_range(7));
            wbv = $urandom_range(1) == 1;
            if (wbv && m_pend[wba] == 0 && $urandom_range(19) != 0) wbv = 1'b0;
            drv(rst, fl, iv, rdw, rd, u1, a1, u2, a2, wbv, wba, $urandom);
        end
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
